// File: rtl/wave_capture_pkg.sv
// Shared types and helpers for the multi-channel waveform capture engine.
package wave_capture_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ARMED,
    ACTIVE,
    WAIT
  } state_t;

  typedef enum logic {
    TRIG_RISING  = 1'b0,
    TRIG_FALLING = 1'b1
  } trig_mode_t;

  // Keep the top out_w bits of a sample_w two's-complement value and flip the sign bit (offset binary).
  function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] sample,
                                                 input int unsigned sample_w,
                                                 input int unsigned out_w);
    logic [MAX_W-1:0] r;
    r = sample >> (sample_w - out_w);
    r = r & ((MAX_W'(1) << out_w) - MAX_W'(1));
    r = r ^ (MAX_W'(1) << (out_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/wave_trigger_detect.sv
// Threshold-crossing and auto-timeout trigger detector; outputs are combinational on the strobe.
module wave_trigger_detect
  import wave_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned TO_W     = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       armed,
  input  logic                       rearm,
  input  logic                       strobe,
  input  logic signed [SAMPLE_W-1:0] cur,
  input  logic signed [SAMPLE_W-1:0] threshold,
  input  trig_mode_t                 mode,
  input  logic                       auto_en,
  input  logic [TO_W-1:0]            auto_timeout,
  output logic                       trig_real,
  output logic                       trig_auto
);

  logic signed [SAMPLE_W-1:0] prev;
  logic                       prev_valid;
  logic [TO_W-1:0]            to_cnt;
  logic                       hit;
  logic                       cur_ge;
  logic                       prev_ge;

  assign hit     = strobe & armed;
  assign cur_ge  = (cur >= threshold);
  assign prev_ge = (prev >= threshold);

  always_comb begin
    trig_real = 1'b0;
    if (hit && prev_valid) begin
      if (mode == TRIG_FALLING) trig_real = prev_ge & ~cur_ge;
      else                      trig_real = ~prev_ge & cur_ge;
    end
  end

  // The count seen on a strobe is the number of earlier armed strobes.
  assign trig_auto = hit & auto_en & (to_cnt == auto_timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      to_cnt     <= '0;
    end else if (rearm) begin
      prev_valid <= 1'b0;
      to_cnt     <= '0;
    end else if (hit) begin
      prev       <= cur;
      prev_valid <= 1'b1;
      to_cnt     <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered capture into the non-displayed half of a double-buffered sample RAM.
module wave_capture_mc
  import wave_capture_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TO_W     = 12,
  localparam int unsigned TRIG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] new_sample_in,
  input  logic [TRIG_W-1:0]          trig_ch,
  input  logic                       trig_falling,
  input  logic [SAMPLE_W-1:0]        threshold,
  input  logic                       auto_en,
  input  logic [TO_W-1:0]            auto_timeout,
  input  logic [3:0]                 decim,
  input  logic                       wave_display_idle,
  output logic [ADDR_W:0]            write_address,
  output logic                       write_enable,
  output logic [NUM_CH*OUT_W-1:0]    write_sample,
  output logic                       read_index,
  output logic                       auto_triggered,
  output logic                       capturing
);

  state_t                     state;
  logic [ADDR_W-1:0]          index;
  logic [3:0]                 dcnt;
  logic [3:0]                 decim_l;
  logic signed [SAMPLE_W-1:0] chan [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]    conv_bus;
  logic                       trig_real;
  logic                       trig_auto;
  logic                       rearm;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign chan[k] = new_sample_in[k*SAMPLE_W +: SAMPLE_W];
    assign conv_bus[k*OUT_W +: OUT_W] =
      OUT_W'(to_offset(MAX_W'(new_sample_in[k*SAMPLE_W +: SAMPLE_W]), SAMPLE_W, OUT_W));
  end

  assign rearm = (state == WAIT) && wave_display_idle;

  wave_trigger_detect #(
    .SAMPLE_W (SAMPLE_W),
    .TO_W     (TO_W)
  ) u_trig (
    .clk          (clk),
    .reset        (reset),
    .armed        (state == ARMED),
    .rearm        (rearm),
    .strobe       (new_sample_ready),
    .cur          (chan[trig_ch]),
    .threshold    (threshold),
    .mode         (trig_mode_t'(trig_falling)),
    .auto_en      (auto_en),
    .auto_timeout (auto_timeout),
    .trig_real    (trig_real),
    .trig_auto    (trig_auto)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARMED;
      index          <= '0;
      dcnt           <= '0;
      decim_l        <= '0;
      write_address  <= '0;
      write_enable   <= 1'b0;
      write_sample   <= '0;
      read_index     <= 1'b0;
      auto_triggered <= 1'b0;
      capturing      <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        ARMED: begin
          if (trig_real || trig_auto) begin
            write_enable   <= 1'b1;
            write_address  <= {~read_index, {ADDR_W{1'b0}}};
            write_sample   <= conv_bus;
            decim_l        <= decim;
            dcnt           <= '0;
            index          <= ADDR_W'(1);
            auto_triggered <= ~trig_real;
            capturing      <= 1'b1;
            state          <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            if (dcnt == decim_l) begin
              dcnt          <= '0;
              write_enable  <= 1'b1;
              write_address <= {~read_index, index};
              write_sample  <= conv_bus;
              index         <= index + 1'b1;
              if (index == '1) begin
                capturing <= 1'b0;
                state     <= WAIT;
              end
            end else begin
              dcnt <= dcnt + 4'd1;
            end
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_mc.sv
// Directed-random bench for wave_capture_mc checked against a frame-level reference model.
module tb_wave_capture_mc;

  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 16;
  localparam int OUT_W    = 8;
  localparam int ADDR_W   = 8;
  localparam int TO_W     = 12;
  localparam int FRAME    = 1 << ADDR_W;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       new_sample_ready = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] new_sample_in = '0;
  logic [0:0]                 trig_ch = '0;
  logic                       trig_falling = 1'b0;
  logic [SAMPLE_W-1:0]        threshold = '0;
  logic                       auto_en = 1'b0;
  logic [TO_W-1:0]            auto_timeout = '0;
  logic [3:0]                 decim = '0;
  logic                       wave_display_idle = 1'b0;
  logic [ADDR_W:0]            write_address;
  logic                       write_enable;
  logic [NUM_CH*OUT_W-1:0]    write_sample;
  logic                       read_index;
  logic                       auto_triggered;
  logic                       capturing;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_auto = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] samples [2048];

  always #5 clk = ~clk;

  wave_capture_mc #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .ADDR_W   (ADDR_W),
    .TO_W     (TO_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .trig_ch           (trig_ch),
    .trig_falling      (trig_falling),
    .threshold         (threshold),
    .auto_en           (auto_en),
    .auto_timeout      (auto_timeout),
    .decim             (decim),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .auto_triggered    (auto_triggered),
    .capturing         (capturing)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ch_val(input int i, input int ch);
    logic [NUM_CH*SAMPLE_W-1:0] w;
    w = samples[i];
    return int'($signed(w[ch*SAMPLE_W +: SAMPLE_W]));
  endfunction

  // Offset binary as arithmetic: add half scale, then drop the low bits.
  function automatic logic [NUM_CH*OUT_W-1:0] exp_word(input int i);
    logic [NUM_CH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++)
      r[c*OUT_W +: OUT_W] = OUT_W'((ch_val(i, c) + (1 << (SAMPLE_W-1))) >> (SAMPLE_W-OUT_W));
    return r;
  endfunction

  // Predict the trigger strobe from the sample list, then the stored strobes from the decimation step.
  task automatic run_frame(input int nstr, input int gap, input bit ri);
    int t = -1;
    bit is_auto = 1'b0;
    int d;
    int thr;
    int last;
    thr = int'($signed(threshold));
    d = int'(decim);
    for (int i = 0; i < nstr; i++) begin
      int p, c;
      bit rl, au;
      c = ch_val(i, int'(trig_ch));
      p = (i > 0) ? ch_val(i-1, int'(trig_ch)) : 0;
      rl = (i > 0) && (trig_falling ? (p >= thr && c < thr) : (p < thr && c >= thr));
      au = auto_en && (i == int'(auto_timeout));
      if (rl || au) begin
        t = i;
        is_auto = !rl;
        break;
      end
    end
    last = t + (FRAME-1)*(d+1);
    for (int i = 0; i < nstr; i++) begin
      int k;
      bit we_exp, cap_exp;
      new_sample_in = samples[i];
      new_sample_ready = 1'b1;
      @(posedge clk);
      #1;
      new_sample_ready = 1'b0;
      k = -1;
      if (t >= 0 && i >= t && (i-t) % (d+1) == 0 && (i-t)/(d+1) < FRAME) k = (i-t)/(d+1);
      we_exp = (k >= 0);
      cap_exp = (t >= 0 && i >= t && i < last);
      chk("write_enable", 64'(write_enable), 64'(we_exp));
      if (we_exp) begin
        chk("write_address", 64'(write_address), 64'({~ri, ADDR_W'(k)}));
        chk("write_sample", 64'(write_sample), 64'(exp_word(i)));
      end
      chk("capturing", 64'(capturing), 64'(cap_exp));
      if (t >= 0 && i >= t) last_auto = is_auto;
      chk("auto_triggered", 64'(auto_triggered), 64'(last_auto));
      chk("read_index", 64'(read_index), 64'(ri));
      if (i == t) decim = 4'($urandom_range(0, 15));
      for (int g = 1; g < gap; g++) begin
        @(posedge clk);
        #1;
        chk("write_enable_gap", 64'(write_enable), 64'(0));
      end
    end
  endtask

  task automatic pulse_idle(input bit ri_new);
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
    chk("read_index_toggle", 64'(read_index), 64'(ri_new));
  endtask

  initial begin
    int thr_b;
    #12;
    chk("rst_write_address", 64'(write_address), 64'(0));
    chk("rst_write_enable", 64'(write_enable), 64'(0));
    chk("rst_write_sample", 64'(write_sample), 64'(0));
    chk("rst_read_index", 64'(read_index), 64'(0));
    chk("rst_auto_triggered", 64'(auto_triggered), 64'(0));
    chk("rst_capturing", 64'(capturing), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Rising ramp through zero on channel 0.
    for (int i = 0; i < 264; i++) samples[i] = {16'($urandom), 16'(i - 4)};
    trig_ch = 1'b0; trig_falling = 1'b0; threshold = '0; auto_en = 1'b0; decim = '0;
    run_frame(264, 2, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      chk("hold_write_enable", 64'(write_enable), 64'(0));
      chk("hold_read_index", 64'(read_index), 64'(0));
    end
    pulse_idle(1'b1);

    // Falling crossing on channel 1 while channel 0 sits at full scale.
    thr_b = int'($urandom_range(0, 2000)) - 1000;
    threshold = 16'(thr_b);
    for (int i = 0; i < 262; i++) samples[i] = {16'($urandom), 16'h7FFF};
    samples[2] = {16'(thr_b + 500), 16'h7FFF};
    samples[3] = {16'(thr_b - 500), 16'h7FFF};
    trig_ch = 1'b1; trig_falling = 1'b1; decim = '0;
    run_frame(262, 1, 1'b1);
    pulse_idle(1'b0);

    // Auto-trigger on a flat input.
    for (int i = 0; i < 263; i++) samples[i] = {16'd100, 16'd100};
    trig_ch = 1'b0; trig_falling = 1'b0; threshold = '0;
    auto_en = 1'b1; auto_timeout = 12'd5; decim = '0;
    run_frame(263, 2, 1'b0);
    chk("auto_flag_after_frame", 64'(auto_triggered), 64'(1));
    auto_en = 1'b0;
    pulse_idle(1'b1);

    // Partial frame aborted by reset after index 99 is written.
    for (int i = 0; i < 104; i++) begin
      if (i < 5) samples[i] = {16'($urandom), 16'(i - 4)};
      else       samples[i] = {16'($urandom), 16'(-int'($urandom_range(1, 1000)))};
    end
    decim = '0;
    run_frame(104, 2, 1'b1);
    #1 reset = 1'b0;
    #2;
    chk("abort_write_address", 64'(write_address), 64'(0));
    chk("abort_write_enable", 64'(write_enable), 64'(0));
    chk("abort_write_sample", 64'(write_sample), 64'(0));
    chk("abort_read_index", 64'(read_index), 64'(0));
    chk("abort_auto_triggered", 64'(auto_triggered), 64'(0));
    chk("abort_capturing", 64'(capturing), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    last_auto = 1'b0;

    // First post-reset strobe crosses relative to the pre-reset sample but must not trigger.
    for (int i = 0; i < 261; i++) samples[i] = {16'($urandom), 16'($urandom)};
    samples[0] = {16'($urandom), 16'(5)};
    samples[1] = {16'($urandom), 16'(6)};
    samples[2] = {16'($urandom), 16'(-3)};
    samples[3] = {16'($urandom), 16'(2)};
    decim = '0;
    run_frame(261, 2, 1'b0);
    pulse_idle(1'b1);

    // Decimated capture with back-to-back strobes.
    for (int i = 0; i < 1025; i++) samples[i] = {16'($urandom), 16'($urandom)};
    samples[0] = {16'($urandom), 16'(-100)};
    samples[1] = {16'($urandom), 16'(100)};
    decim = 4'd3;
    run_frame(1025, 1, 1'b1);
    pulse_idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
